// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the EX-stage divider requester: ALU op encodings and FSM states.
// Imported by div_issue_ctrl; the bench uses the op encodings to build stimulus.
package div_issue_ctrl_pkg;

  localparam int unsigned ALU_OP_W = 8;

  localparam logic [ALU_OP_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [ALU_OP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;

  typedef enum logic [1:0] {
    DIVC_IDLE = 2'b00,
    DIVC_BUSY = 2'b01,
    DIVC_DONE = 2'b10
  } divc_state_e;

endpackage

// File: rtl/div_issue_ctrl.sv
// EX-stage requester for the multi-cycle divider: launch, stall, single HI/LO write, flush abort.
// Optional build macro DIV_ZERO_FASTPATH_EN: divide-by-zero bypasses the divider.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int unsigned OP_W   = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ex_valid,
  input  logic [OP_W-1:0]     ex_op,
  input  logic [DATA_W-1:0]   ex_dividend,
  input  logic [DATA_W-1:0]   ex_divisor,
  input  logic                ex_hold,
  input  logic                flush,
  input  logic                div_done,
  input  logic [2*DATA_W-1:0] div_result,
  output logic                div_start,
  output logic                div_signed,
  output logic [DATA_W-1:0]   div_dividend,
  output logic [DATA_W-1:0]   div_divisor,
  output logic                div_abort,
  output logic                stall_ex,
  output logic                hilo_we,
  output logic [DATA_W-1:0]   hi_wdata,
  output logic [DATA_W-1:0]   lo_wdata
);

  divc_state_e       state_q, state_d;
  logic [DATA_W-1:0] dividend_q, divisor_q;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic              signed_q;
  logic              hilo_we_q;

  logic              op_div, op_divu;
  logic              is_div;
  logic              zero_fast;
  logic              take_fast;
  logic              accept_done;

  assign op_div  = (ex_op == OP_W'(EXE_DIV_OP));
  assign op_divu = (ex_op == OP_W'(EXE_DIVU_OP));

  // resetn gating keeps the combinational launch/stall outputs low while reset is held
  assign is_div = resetn & ex_valid & ~flush & (op_div | op_divu);

`ifdef DIV_ZERO_FASTPATH_EN
  assign zero_fast = (ex_divisor == '0);
`else
  assign zero_fast = 1'b0;
`endif

  assign take_fast   = (state_q == DIVC_IDLE) & is_div & zero_fast;
  assign accept_done = (state_q == DIVC_BUSY) & div_done & ~flush;

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    stall_ex  = 1'b0;
    div_abort = 1'b0;
    unique case (state_q)
      DIVC_IDLE: begin
        if (is_div) begin
          stall_ex = 1'b1;
          if (zero_fast) begin
            state_d = DIVC_DONE;
          end else begin
            div_start = 1'b1;
            state_d   = DIVC_BUSY;
          end
        end
      end
      DIVC_BUSY: begin
        stall_ex = 1'b1;
        // abort has priority over a coincident div_done
        if (flush) begin
          div_abort = 1'b1;
          state_d   = DIVC_IDLE;
        end else if (div_done) begin
          state_d = DIVC_DONE;
        end
      end
      DIVC_DONE: begin
        if (flush || !ex_hold) begin
          state_d = DIVC_IDLE;
        end
      end
      default: state_d = DIVC_IDLE;
    endcase
  end

  // Operands bypass to the divider in the launch cycle, then come from the registers
  assign div_signed   = div_start ? op_div      : signed_q;
  assign div_dividend = div_start ? ex_dividend : dividend_q;
  assign div_divisor  = div_start ? ex_divisor  : divisor_q;

  assign hilo_we  = hilo_we_q;
  assign hi_wdata = hi_q;
  assign lo_wdata = lo_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= DIVC_IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      signed_q   <= 1'b0;
      hilo_we_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q   <= state_d;
      hilo_we_q <= accept_done | take_fast;
      if (div_start) begin
        dividend_q <= ex_dividend;
        divisor_q  <= ex_divisor;
        signed_q   <= op_div;
      end
      if (accept_done) begin
        hi_q <= div_result[2*DATA_W-1:DATA_W];
        lo_q <= div_result[DATA_W-1:0];
      end else if (take_fast) begin
        hi_q <= ex_dividend;
        lo_q <= '1;
      end
    end
  end

endmodule
